// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    CSUM      = 3'd4,
    FINISH    = 3'd5
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after rr_ptr, wrapping at N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  // Scan from the farthest offset down so the closest valid requester wins.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[wrap(int'(rr_ptr) + k)]) begin
        index = IDX_W'(wrap(int'(rr_ptr) + k));
        any   = 1'b1;
      end
    end
    if (any) grant[index] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter in front of a single UART byte sender.
// Optional trailing XOR checksum byte per packet: define UART_TX_ARB_CHECKSUM_EN.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = BYTE_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_do_transmit,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_is_busy,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      pkt_done,
  output state_t                    fsm_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gidx;
  logic               last;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  cur_byte;
  logic [IDX_W-1:0]   ptr_next;
  logic               take;
`ifdef UART_TX_ARB_CHECKSUM_EN
  logic [DATA_W-1:0]  csum;
  logic               csum_phase;
`endif

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .index     (pick_idx),
    .any       (pick_any)
  );

  // Handshake: a byte moves on any cycle where req_valid[i] && req_ready[i];
  // ready is offered only to the granted requester, in SEND, while the sender is idle.
  assign req_ready = (state == SEND && !tx_is_busy) ? grant : '0;
  assign take      = (state == SEND) && !tx_is_busy && req_valid[gidx];
  assign cur_byte  = req_data[int'(gidx)*DATA_W +: DATA_W];
  assign ptr_next  = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + IDX_W'(1);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      gidx           <= '0;
      grant          <= '0;
      last           <= 1'b0;
      tx_do_transmit <= 1'b0;
      tx_data        <= '0;
      pkt_done       <= 1'b0;
`ifdef UART_TX_ARB_CHECKSUM_EN
      csum           <= '0;
      csum_phase     <= 1'b0;
`endif
    end else begin
      tx_do_transmit <= 1'b0;
      pkt_done       <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_grant;
            gidx  <= pick_idx;
            state <= SEND;
          end
        end
        SEND: begin
          if (take) begin
            tx_data        <= cur_byte;
            tx_do_transmit <= 1'b1;
            last           <= req_last[gidx];
`ifdef UART_TX_ARB_CHECKSUM_EN
            csum           <= csum ^ cur_byte;
`endif
            state          <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_is_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_is_busy) begin
            if (!last) begin
              state <= SEND;
            end else begin
`ifdef UART_TX_ARB_CHECKSUM_EN
              if (csum_phase) begin
                state    <= FINISH;
                pkt_done <= 1'b1;
              end else begin
                state <= CSUM;
              end
`else
              state    <= FINISH;
              pkt_done <= 1'b1;
`endif
            end
          end
        end
`ifdef UART_TX_ARB_CHECKSUM_EN
        CSUM: begin
          tx_data        <= csum;
          tx_do_transmit <= 1'b1;
          csum_phase     <= 1'b1;
          state          <= WAIT_BUSY;
        end
`endif
        FINISH: begin
          rr_ptr <= ptr_next;
          grant  <= '0;
          state  <= IDLE;
`ifdef UART_TX_ARB_CHECKSUM_EN
          csum       <= '0;
          csum_phase <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART byte sender among NUM_REQ packet-producing requesters, e.g. DNN result drain and debug/status dump.
- Grants round-robin and holds the grant for a whole packet, so packets never interleave on TxD.
- Handles the sender handshake: one-cycle doTransmit pulse, then waits for isBusy to rise and then fall.
- Sits between the accelerator's output logic and the UART byte sender.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- DATA_W, 8, byte width; fixed by the sender interface.

Ports:
- clk  in  1  system clock (W5 domain, 6.25 MHz).
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  packed bytes; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a packet.
- req_ready  out  NUM_REQ  byte accepted when valid&ready.
- tx_do_transmit  out  1  to sender doTransmit.
- tx_data  out  8  to sender TxData.
- tx_is_busy  in  1  from sender isBusy.
- grant  out  NUM_REQ  one-hot owner of the current packet; 0 when idle.
- pkt_done  out  1  one-cycle pulse after a packet's final byte (incl. checksum) completes.

Behaviour:
- Reset: state=IDLE; rr_ptr=0; grant=0; req_ready=0; tx_do_transmit=0; tx_data=0; pkt_done=0; csum=0. Reset mid-packet abandons the packet; no partial resume.
- IDLE: if any req_valid, pick the first valid index scanning rr_ptr, rr_ptr+1, … (mod NUM_REQ). Register grant and go to SEND next cycle. If nothing is valid, stay.
- SEND: req_ready[g] = (tx_is_busy==0), combinational; all other ready bits are 0.
  - On valid&ready: tx_data<=byte; tx_do_transmit<=1 for exactly one cycle; latch last; csum<=csum^byte. Go to WAIT_BUSY.
  - If the requester drops valid mid-packet, grant is held and the block waits indefinitely.
- WAIT_BUSY: wait for tx_is_busy==1, then go to WAIT_DONE. tx_do_transmit is already low.
- WAIT_DONE: wait for tx_is_busy==0.
  - If not last: go to SEND.
  - If last: go to CSUM when UART_TX_ARB_CHECKSUM_EN is defined, else to FINISH.
- CSUM (feature only): tx_data<=csum; tx_do_transmit<=1 for one cycle; set csum_phase. Then WAIT_BUSY → WAIT_DONE → FINISH. req_ready stays 0 throughout.
- FINISH (1 cycle): pkt_done=1; rr_ptr<=g+1 (wraps to 0 at NUM_REQ); grant<=0; csum<=0. Go to IDLE.
- Throughput bound: one byte per sender frame, ~11 bit times. The arbiter adds ≤3 idle cycles per byte.
- No byte is lost or duplicated. tx_do_transmit is never asserted while tx_is_busy==1 or in the cycle after a prior pulse.
- NUM_REQ=1: behaves as a pass-through packet sequencer; rr_ptr stays 0.
- A single-byte packet (valid & last on the first byte) is legal.

Optional Feature:
- Macro UART_TX_ARB_CHECKSUM_EN.
  - Defined: after each packet's last byte, one extra byte is sent, equal to the XOR of all packet bytes.
  - Undefined: the CSUM state and csum register are absent; WAIT_DONE on last goes directly to FINISH.

Decomposition:
- Package uart_tx_pkg holds:
  - state enum (IDLE, SEND, WAIT_BUSY, WAIT_DONE, CSUM, FINISH);
  - BYTE_W=8;
  - default NUM_REQ.
- Sub-module rr_pick: combinational round-robin picker. Inputs req_valid and rr_ptr; outputs one-hot grant and index.

Test Plan:
- Single packet: req0 sends 0x41,0x42,0x43 (last) with a sender model of busy=539 cycles → exactly 3 doTransmit pulses, TxData 0x41,0x42,0x43 in order; one pkt_done; grant=0001 throughout.
- Contention: req0 and req2 both valid at once, rr_ptr=0 → req0's full packet, then req2's; rr_ptr=3 afterwards. Next simultaneous req1/req3 → req3 first.
- Valid gap: req1 drops valid for 2000 cycles mid-packet while req0 is valid → grant stays with req1; no pulse during the gap; req0 served after req1's last byte.
- Checksum (macro on): bytes 0x12,0x34 → third transmitted byte 0x26; pkt_done only after it completes. Macro off → 2 bytes only.
- Busy at entry: tx_is_busy held 1 by external stimulus when SEND is entered → req_ready stays 0 and no pulse until busy falls.
- Reset mid-packet: assert reset during WAIT_DONE of byte 2 → next cycle all outputs at reset values; a new request restarts arbitration with rr_ptr=0.
